// File: rtl/xc_sha3_fu.sv
// -----------------------------------------------------------------------------
// xc_sha3_fu
// Execute-stage functional unit for the XCrypto SHA3 lane-index instructions
// (xc.sha3.xy / x1 / x2 / x4 / yx). Two-stage pipeline:
//   stage A : reduces rs1 and rs2 modulo 5 and captures op and shamt
//   stage B : combines the reduced coordinates into a lane index, shifts it
//             and holds it on the output until the consumer takes it
// Full throughput and back-pressure are handled by valid/ready handshakes on
// both sides.
//
// Ports:
//   g_clk, g_rst          core clock, synchronous active-high reset
//   flush                 pipeline flush (only with XC_SHA3_FU_FLUSH_EN)
//   in_valid / in_ready   operation handshake from dispatch
//   in_rs1, in_rs2        x and y coordinates (XLEN bits, unsigned)
//   in_shamt              post-shift amount (instruction bits [31:30])
//   in_op                 0=xy 1=x1 2=x2 3=x4 4=yx, 5..7 reserved
//   out_valid / out_ready result handshake to writeback
//   out_result            lane index << shamt, zero-extended to XLEN
//   out_bad_op            result came from a reserved op encoding
//
// Configuration macro: XC_SHA3_FU_FLUSH_EN adds the flush input.
// XLEN must be a multiple of 4 and greater than 8.
// -----------------------------------------------------------------------------
module xc_sha3_fu #(
   parameter int XLEN = 32
) (
   input  logic            g_clk,
   input  logic            g_rst,
`ifdef XC_SHA3_FU_FLUSH_EN
   input  logic            flush,
`endif
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [1:0]      in_shamt,
   input  logic [2:0]      in_op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_bad_op
);

   // Since 16 mod 5 == 1, a word is congruent to the sum of its nibbles,
   // which keeps the modulo operator on a narrow value.
   function automatic logic [2:0] mod5_word(input logic [XLEN-1:0] v);
      logic [15:0] sum;
      sum = 16'd0;
      for (int i = 0; i < XLEN / 4; i++) begin
         sum = sum + {12'd0, v[4*i +: 4]};
      end
      return 3'(sum % 16'd5);
   endfunction

   // Both operands are already below 5, so one conditional subtract suffices.
   function automatic logic [2:0] add_mod5(input logic [2:0] x, input logic [2:0] y);
      logic [3:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= 4'd5) begin
         s = s - 4'd5;
      end else begin
         s = s;
      end
      return s[2:0];
   endfunction

   logic       flush_s;
   logic       b_load_s;
   logic       in_ready_s;
   logic       in_xfer_s;

   logic       a_valid_q, a_valid_d;
   logic [2:0] a_x_q, a_x_d;
   logic [2:0] a_y_q, a_y_d;
   logic [2:0] a_op_q, a_op_d;
   logic [1:0] a_shamt_q, a_shamt_d;

   logic       b_valid_q, b_valid_d;
   logic [7:0] b_result_q, b_result_d;
   logic       b_bad_q, b_bad_d;

   logic [2:0] xi_s;
   logic [2:0] yi_s;
   logic       bad_s;
   logic [4:0] idx_s;
   logic [7:0] res_s;

   // Handshake and stage-advance control.
   always_comb begin
`ifdef XC_SHA3_FU_FLUSH_EN
      flush_s = flush;
`else
      flush_s = 1'b0;
`endif
      b_load_s   = a_valid_q && (!b_valid_q || out_ready);
      in_ready_s = (!a_valid_q || b_load_s) && !flush_s;
      in_xfer_s  = in_valid && in_ready_s;
   end

   // Stage B combine: coordinate arithmetic, lane index and post-shift.
   always_comb begin
      xi_s  = a_x_q;
      yi_s  = a_y_q;
      bad_s = 1'b0;
      case (a_op_q)
         3'd0: xi_s = a_x_q;
         3'd1: xi_s = add_mod5(a_x_q, 3'd1);
         3'd2: xi_s = add_mod5(a_x_q, 3'd2);
         3'd3: xi_s = add_mod5(a_x_q, 3'd4);
         3'd4: begin
            // yx: xi = b, yi = 2a + 3b (mod 5)
            xi_s = a_y_q;
            yi_s = add_mod5(add_mod5(a_x_q, a_x_q),
                            add_mod5(a_y_q, add_mod5(a_y_q, a_y_q)));
         end
         default: bad_s = 1'b1;
      endcase
      idx_s = {2'b00, xi_s} + {yi_s, 2'b00} + {2'b00, yi_s};
      if (bad_s) begin
         res_s = 8'd0;
      end else begin
         res_s = {3'b000, idx_s} << a_shamt_q;
      end
   end

   // Stage A next state: load on input transfer, empty when it hands to B.
   always_comb begin
      a_valid_d = a_valid_q;
      a_x_d     = a_x_q;
      a_y_d     = a_y_q;
      a_op_d    = a_op_q;
      a_shamt_d = a_shamt_q;
      if (flush_s) begin
         a_valid_d = 1'b0;
      end else if (in_xfer_s) begin
         a_valid_d = 1'b1;
         a_x_d     = mod5_word(in_rs1);
         a_y_d     = mod5_word(in_rs2);
         a_op_d    = in_op;
         a_shamt_d = in_shamt;
      end else if (b_load_s) begin
         a_valid_d = 1'b0;
      end else begin
         a_valid_d = a_valid_q;
      end
   end

   // Stage B next state: load from A, drain on output transfer, else hold.
   always_comb begin
      b_valid_d  = b_valid_q;
      b_result_d = b_result_q;
      b_bad_d    = b_bad_q;
      if (flush_s) begin
         b_valid_d = 1'b0;
      end else if (b_load_s) begin
         b_valid_d  = 1'b1;
         b_result_d = res_s;
         b_bad_d    = bad_s;
      end else if (out_ready) begin
         b_valid_d = 1'b0;
      end else begin
         b_valid_d = b_valid_q;
      end
   end

   // Pipeline registers with synchronous reset.
   always_ff @(posedge g_clk) begin
      if (g_rst) begin
         a_valid_q  <= 1'b0;
         a_x_q      <= 3'd0;
         a_y_q      <= 3'd0;
         a_op_q     <= 3'd0;
         a_shamt_q  <= 2'd0;
         b_valid_q  <= 1'b0;
         b_result_q <= 8'd0;
         b_bad_q    <= 1'b0;
      end else begin
         a_valid_q  <= a_valid_d;
         a_x_q      <= a_x_d;
         a_y_q      <= a_y_d;
         a_op_q     <= a_op_d;
         a_shamt_q  <= a_shamt_d;
         b_valid_q  <= b_valid_d;
         b_result_q <= b_result_d;
         b_bad_q    <= b_bad_d;
      end
   end

   assign in_ready   = in_ready_s;
   assign out_valid  = b_valid_q;
   assign out_result = {{(XLEN-8){1'b0}}, b_result_q};
   assign out_bad_op = b_bad_q;

endmodule

// File: tb/tb_xc_sha3_fu.sv
// -----------------------------------------------------------------------------
// tb_xc_sha3_fu
// Directed and randomized bench for xc_sha3_fu. A queue-based reference model
// computes each lane index from the instruction definitions; every visible
// result is compared with the oldest outstanding expectation.
// Build with XC_SHA3_FU_FLUSH_EN to exercise the flush port.
// -----------------------------------------------------------------------------
module tb_xc_sha3_fu;

   logic        g_clk = 1'b0;
   logic        g_rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_rs1 = 32'd0;
   logic [31:0] in_rs2 = 32'd0;
   logic [1:0]  in_shamt = 2'd0;
   logic [2:0]  in_op = 3'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_bad_op;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   logic [32:0] exp_q[$];
   logic        prev_stall = 1'b0;

   xc_sha3_fu #(.XLEN(32)) dut (
      .g_clk      (g_clk),
      .g_rst      (g_rst),
`ifdef XC_SHA3_FU_FLUSH_EN
      .flush      (flush),
`endif
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_shamt   (in_shamt),
      .in_op      (in_op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_bad_op (out_bad_op)
   );

   always #5 g_clk = ~g_clk;

   // Reference: {bad_op, result} straight from the instruction definitions.
   function automatic logic [32:0] ref_model(input logic [2:0] op, input logic [31:0] rs1,
                                             input logic [31:0] rs2, input logic [1:0] sh);
      int unsigned a, b, xi, yi;
      a  = rs1 % 32'd5;
      b  = rs2 % 32'd5;
      xi = a;
      yi = b;
      case (op)
         3'd0: xi = a;
         3'd1: xi = (a + 32'd1) % 32'd5;
         3'd2: xi = (a + 32'd2) % 32'd5;
         3'd3: xi = (a + 32'd4) % 32'd5;
         3'd4: begin
            xi = b;
            yi = (32'd2 * a + 32'd3 * b) % 32'd5;
         end
         default: return {1'b1, 32'd0};
      endcase
      return {1'b0, 32'((xi + 32'd5 * yi) << sh)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [1:0] sh);
      in_valid = v;
      in_op    = op;
      in_rs1   = r1;
      in_rs2   = r2;
      in_shamt = sh;
   endtask

   // One clock: sample between edges, update the scoreboard, advance.
   task automatic step();
      #1;
      if (!g_rst) begin
         if (flush) chk("flush_in_ready", 64'(in_ready), 64'd0);
         if (prev_stall) chk("stall_hold_valid", 64'(out_valid), 64'd1);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
               chk("result", 64'({out_bad_op, out_result}), 64'(exp_q[0]));
               if (out_ready) exp_q.delete(0);
            end
         end
         if (in_valid && in_ready && !flush)
            exp_q.push_back(ref_model(in_op, in_rs1, in_rs2, in_shamt));
         prev_stall = out_valid && !out_ready && !flush;
      end else begin
         prev_stall = 1'b0;
      end
      @(posedge g_clk);
      if (g_rst || flush) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end
      #1;
   endtask

   initial begin
      // Reset then idle
      g_rst = 1'b1;
      step();
      step();
      g_rst = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_result", 64'(out_result), 64'd0);
      chk("rst_out_bad_op", 64'(out_bad_op), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Single xy op, two-cycle latency
      out_ready = 1'b1;
      drive(1'b1, 3'd0, 32'd7, 32'd13, 2'd2);
      step();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 2'd0);
      chk("lat_not_yet", 64'(out_valid), 64'd0);
      step();
      chk("xy_valid", 64'(out_valid), 64'd1);
      chk("xy_result", 64'(out_result), 64'd68);
      chk("xy_bad", 64'(out_bad_op), 64'd0);
      step();
      chk("xy_drained", 64'(out_valid), 64'd0);

      // Back-to-back ops, consecutive in-order results
      drive(1'b1, 3'd4, 32'd1, 32'd2, 2'd0);
      step();
      drive(1'b1, 3'd3, 32'd3, 32'd0, 2'd3);
      step();
      chk("b2b_yx", 64'(out_result), 64'd17);
      drive(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0);
      step();
      chk("b2b_x4", 64'(out_result), 64'd16);
      drive(1'b0, 3'd0, 32'd0, 32'd0, 2'd0);
      step();
      chk("b2b_x1", 64'(out_result), 64'd1);
      chk("b2b_x1_valid", 64'(out_valid), 64'd1);
      step();
      chk("b2b_drained", 64'(out_valid), 64'd0);

      // Back-pressure: third op waits until out_ready returns
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 32'd1, 32'd2, 2'd0);
      step();
      drive(1'b1, 3'd0, 32'd3, 32'd4, 2'd0);
      chk("bp_ready_after_1", 64'(in_ready), 64'd1);
      step();
      drive(1'b1, 3'd0, 32'd5, 32'd6, 2'd0);
      chk("bp_ready_after_2", 64'(in_ready), 64'd0);
      chk("bp_first", 64'(out_result), 64'd11);
      step();
      step();
      chk("bp_still_stalled", 64'(in_ready), 64'd0);
      chk("bp_held", 64'(out_result), 64'd11);
      out_ready = 1'b1;
      step();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 2'd0);
      chk("bp_second", 64'(out_result), 64'd23);
      step();
      chk("bp_third", 64'(out_result), 64'd5);
      step();
      chk("bp_drained", 64'(out_valid), 64'd0);

      // Reserved op followed by a valid op
      drive(1'b1, 3'd6, 32'd9, 32'd9, 2'd1);
      step();
      drive(1'b1, 3'd0, 32'd9, 32'd9, 2'd0);
      step();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 2'd0);
      chk("resv_result", 64'(out_result), 64'd0);
      chk("resv_bad", 64'(out_bad_op), 64'd1);
      step();
      chk("after_resv_bad", 64'(out_bad_op), 64'd0);
      chk("after_resv_result", 64'(out_result), 64'd24);
      step();

      // Reset mid-operation discards in-flight ops
      drive(1'b1, 3'd2, 32'd4, 32'd1, 2'd1);
      step();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 2'd0);
      g_rst = 1'b1;
      step();
      g_rst = 1'b0;
      chk("midrst_valid", 64'(out_valid), 64'd0);
      step();
      chk("midrst_no_result", 64'(out_valid), 64'd0);

`ifdef XC_SHA3_FU_FLUSH_EN
      // Flush with two ops in flight
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 32'd1, 32'd2, 2'd0);
      step();
      drive(1'b1, 3'd0, 32'd3, 32'd4, 2'd0);
      step();
      drive(1'b1, 3'd0, 32'd5, 32'd6, 2'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 3'd0, 32'd0, 32'd0, 2'd0);
      out_ready = 1'b1;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("flush_no_result", 64'(out_valid), 64'd0);
      end
`endif

      // Randomized traffic against the reference queue
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), $urandom(), $urandom(),
               2'($urandom_range(0, 3)));
         out_ready = $urandom_range(0, 9) < 6;
`ifdef XC_SHA3_FU_FLUSH_EN
         flush = $urandom_range(0, 39) == 0;
`endif
         step();
      end
      flush = 1'b0;
      drive(1'b0, 3'd0, 32'd0, 32'd0, 2'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("drain_out_valid", 64'(out_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
